// File: rtl/regfile_write_queue.sv
// Register-file write queue: buffers writeback requests, drains one per cycle to the
// regfile write port, and forwards still-pending values to the two read addresses.
module regfile_write_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clock,
   input  logic          ctrl_reset,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [4:0]    wb_reg,
   input  logic [31:0]   wb_data,
   output logic          ctrl_writeEnable,
   output logic [4:0]    ctrl_writeReg,
   output logic [31:0]   data_writeReg,
   input  logic [4:0]    ctrl_readRegA,
   input  logic [4:0]    ctrl_readRegB,
   output logic          byp_hitA,
   output logic [31:0]   byp_dataA,
   output logic          byp_hitB,
   output logic [31:0]   byp_dataB,
   output logic [AW:0]   wq_count
);

   logic [DEPTH-1:0][4:0]  ent_reg;
   logic [DEPTH-1:0][31:0] ent_data;
   logic [DEPTH-1:0]       ent_vld;
   logic [AW-1:0]          rd_ptr, wr_ptr;
   logic [AW:0]            count;
   logic                   push, pop;

   assign wb_ready = (count != (AW+1)'(DEPTH));
   // r0 writes complete the handshake but are dropped: r0 is hardwired zero in the regfile
   assign push     = wb_valid & wb_ready & (wb_reg != 5'd0);
   assign pop      = (count != '0);

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         if (pop) begin
            ent_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         if (push) begin
            ent_vld[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         ent_reg[wr_ptr]  <= wb_reg;
         ent_data[wr_ptr] <= wb_data;
      end
   end

   assign wq_count         = count;
   assign ctrl_writeEnable = pop;
   assign ctrl_writeReg    = pop ? ent_reg[rd_ptr]  : 5'd0;
   assign data_writeReg    = pop ? ent_data[rd_ptr] : 32'd0;

   // Walk oldest to youngest so the last match wins; head is included since the
   // regfile has not committed it yet this cycle.
   function automatic logic [32:0] lookup(input logic [4:0] addr);
      logic [32:0]   res;
      logic [AW-1:0] idx;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if (ent_vld[idx] && ent_reg[idx] == addr && addr != 5'd0)
            res = {1'b1, ent_data[idx]};
      end
      return res;
   endfunction

   always_comb begin
      {byp_hitA, byp_dataA} = lookup(ctrl_readRegA);
      {byp_hitB, byp_dataB} = lookup(ctrl_readRegB);
   end

endmodule
